// File: rtl/arb4_pkg.sv
// arb4_pkg: shared state, index type and requester count for the 4-way arbiter
package arb4_pkg;
    localparam int NUM_REQ = 4;
    typedef enum logic [0:0] {EMPTY = 1'b0, FULL = 1'b1} state_t;
    typedef logic [1:0] req_idx_t;
endpackage

// File: rtl/mux4.sv
// mux4: 4-to-1 data select of N-bit words
module mux4
    import arb4_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] d0,
    input  logic [N-1:0] d1,
    input  logic [N-1:0] d2,
    input  logic [N-1:0] d3,
    input  req_idx_t     sel,
    output logic [N-1:0] y
);
    assign y = sel[1] ? (sel[0] ? d3 : d2) : (sel[0] ? d1 : d0);
endmodule

// File: rtl/arb4_sched.sv
// arb4_sched: 4-requester round-robin arbiter into a one-word output register; optional grant_cnt via ARB4_GRANT_CNT_EN
module arb4_sched
    import arb4_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   in_valid,
    input  logic [N-1:0] in0,
    input  logic [N-1:0] in1,
    input  logic [N-1:0] in2,
    input  logic [N-1:0] in3,
    output logic [3:0]   in_ready,
    output logic         out_valid,
    output logic [N-1:0] out_data,
    input  logic         out_ready,
    output logic [1:0]   grant_id
`ifdef ARB4_GRANT_CNT_EN
    ,
    output logic [NUM_REQ-1:0][7:0] grant_cnt
`endif
);
    state_t       state;
    req_idx_t     last_grant, sel, off;
    logic [3:0]   rot;
    logic         slot_free, take;
    logic [N-1:0] mux_out;
    assign slot_free = (state == EMPTY) || out_ready;
    assign take      = slot_free && (|in_valid);
    // rotate so bit 0 is the requester right after last_grant; first set bit wins
    assign rot = 4'({in_valid, in_valid} >> (last_grant + 2'd1));
    assign off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
    assign sel = last_grant + 2'd1 + off;
    assign in_ready  = (rst_n && take) ? (4'b0001 << sel) : 4'b0000;
    assign out_valid = (state == FULL);
    mux4 #(.N(N)) u_mux (
        .d0 (in0),
        .d1 (in1),
        .d2 (in2),
        .d3 (in3),
        .sel(sel),
        .y  (mux_out)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            out_data   <= '0;
            grant_id   <= 2'd0;
            last_grant <= 2'd3;
        end else if (take) begin
            state      <= FULL;
            out_data   <= mux_out;
            grant_id   <= sel;
            last_grant <= sel;
        end else if (out_ready) begin
            state <= EMPTY;
        end
    end
`ifdef ARB4_GRANT_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++)
                if (in_ready[i]) grant_cnt[i] <= grant_cnt[i] + 8'd1;
        end
    end
`endif
endmodule

// File: tb/tb_arb4_sched.sv
// tb_arb4_sched: directed and randomized checks of arb4_sched against a queue-free behavioural model
module tb_arb4_sched;
    localparam int N = 4;
    logic         clk = 1'b0, rst_n = 1'b0, out_ready = 1'b0;
    logic [3:0]   in_valid = 4'b0, in_ready;
    logic [N-1:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0, out_data;
    logic         out_valid;
    logic [1:0]   grant_id;
`ifdef ARB4_GRANT_CNT_EN
    logic [3:0][7:0] grant_cnt;
`endif
    int passed = 0, total = 0;
    logic         m_valid = 1'b0;
    logic [N-1:0] m_data = '0;
    logic [1:0]   m_gid = 2'd0;
    int           m_lg = 3;

    always #5 clk = ~clk;

    arb4_sched #(.N(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in0      (in0),
        .in1      (in1),
        .in2      (in2),
        .in3      (in3),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .grant_id (grant_id)
`ifdef ARB4_GRANT_CNT_EN
        ,
        .grant_cnt(grant_cnt)
`endif
    );

    // search requesters in order last+1 .. last+4 (mod 4); -1 when none asks
    function automatic int pick(input logic [3:0] iv, input int lg);
        for (int k = 1; k <= 4; k++)
            if (iv[(lg + k) % 4]) return (lg + k) % 4;
        return -1;
    endfunction

    function automatic logic [3:0] exp_ready();
        int p;
        p = pick(in_valid, m_lg);
        if (!rst_n || (m_valid && !out_ready) || p < 0) return 4'b0;
        return 4'(1 << p);
    endfunction

    function automatic logic [N-1:0] word(input int i);
        case (i)
            0: return in0;
            1: return in1;
            2: return in2;
            default: return in3;
        endcase
    endfunction

    task automatic tick();
        int p;
        @(posedge clk);
        p = pick(in_valid, m_lg);
        if ((!m_valid || out_ready) && p >= 0) begin
            m_valid = 1'b1;
            m_data  = word(p);
            m_gid   = 2'(p);
            m_lg    = p;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 4'b0;
        out_ready = 1'b0;
        m_valid = 1'b0; m_data = '0; m_gid = 2'd0; m_lg = 3;
        #2 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 4'b0 || grant_id !== 2'd0 || out_data !== '0)
            $display("FAIL reset_initial: got v=%b r=%b g=%0d d=%h want 0 0 0 0", out_valid, in_ready, grant_id, out_data);
        else passed++;
        #2 rst_n = 1'b1;
        @(negedge clk);
        in_valid = 4'b0110; in1 = 4'h5; in2 = 4'h6; out_ready = 1'b1;
        tick();
        total++;
        if (out_valid !== 1'b1 || grant_id !== 2'd1)
            $display("FAIL reset_preload: got v=%b g=%0d want 1 1", out_valid, grant_id);
        else passed++;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 4'b0 || grant_id !== 2'd0 || out_data !== '0)
            $display("FAIL reset_async: got v=%b r=%b g=%0d d=%h want 0 0 0 0", out_valid, in_ready, grant_id, out_data);
        else passed++;
        m_valid = 1'b0; m_data = '0; m_gid = 2'd0; m_lg = 3;
        in_valid = 4'b0;
        #2 rst_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        @(negedge clk);
        in_valid = 4'b0100; in2 = 4'hA; out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 4'b0100) $display("FAIL single_ready: got %b want 0100", in_ready);
        else passed++;
        tick();
        total++;
        if (out_valid !== 1'b1 || out_data !== 4'hA || grant_id !== 2'd2)
            $display("FAIL single_out: got v=%b d=%h g=%0d want 1 a 2", out_valid, out_data, grant_id);
        else passed++;
    endtask

    task automatic test_fairness();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 4'b1111; out_ready = 1'b1;
            {in0, in1, in2, in3} = 16'($urandom);
            tick();
            total++;
            if (out_valid !== 1'b1 || grant_id !== 2'(i % 4) || out_data !== m_data)
                $display("FAIL fairness_%0d: got v=%b g=%0d d=%h want 1 %0d %h", i, out_valid, grant_id, out_data, i % 4, m_data);
            else passed++;
        end
    endtask

    task automatic test_backpressure();
        logic [N-1:0] first;
        do_reset();
        @(negedge clk);
        in_valid = 4'b0011; out_ready = 1'b0; in0 = 4'h3; in1 = 4'hC;
        first = in0;
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in0 = 4'($urandom); in1 = 4'($urandom);
            in_valid = (i == 2) ? 4'b0010 : 4'b0011;
            #1;
            total++;
            if (in_ready !== 4'b0 || out_valid !== 1'b1 || out_data !== first || grant_id !== 2'd0)
                $display("FAIL backpressure_%0d: got r=%b v=%b d=%h g=%0d want 0000 1 %h 0", i, in_ready, out_valid, out_data, grant_id, first);
            else passed++;
            tick();
        end
        @(negedge clk);
        in_valid = 4'b0011; out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 4'b0010) $display("FAIL backpressure_release_ready: got %b want 0010", in_ready);
        else passed++;
        tick();
        total++;
        if (grant_id !== 2'd1 || out_data !== in1)
            $display("FAIL backpressure_release_grant: got g=%0d d=%h want 1 %h", grant_id, out_data, in1);
        else passed++;
    endtask

    task automatic test_skip();
        do_reset();
        @(negedge clk);
        in_valid = 4'b0001; out_ready = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_valid = 4'b1001;
            {in0, in1, in2, in3} = 16'($urandom);
            #1;
            total++;
            if (in_ready !== (i == 0 ? 4'b1000 : 4'b0001))
                $display("FAIL skip_ready_%0d: got %b want %b", i, in_ready, (i == 0 ? 4'b1000 : 4'b0001));
            else passed++;
            tick();
            total++;
            if (grant_id !== (i == 0 ? 2'd3 : 2'd0))
                $display("FAIL skip_grant_%0d: got %0d want %0d", i, grant_id, (i == 0 ? 3 : 0));
            else passed++;
        end
    endtask

    task automatic test_random();
        logic [3:0] er;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            in_valid = 4'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            {in0, in1, in2, in3} = 16'($urandom);
            #1;
            er = exp_ready();
            total++;
            if (in_ready !== er) $display("FAIL random_ready_%0d: got %b want %b", i, in_ready, er);
            else passed++;
            tick();
            total++;
            if (out_valid !== m_valid || (m_valid && (out_data !== m_data || grant_id !== m_gid)))
                $display("FAIL random_out_%0d: got v=%b d=%h g=%0d want %b %h %0d", i, out_valid, out_data, grant_id, m_valid, m_data, m_gid);
            else passed++;
        end
    endtask

`ifdef ARB4_GRANT_CNT_EN
    task automatic test_grant_cnt();
        do_reset();
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            in_valid = 4'b0010; out_ready = 1'b1;
            tick();
            if (i == 254) begin
                total++;
                if (grant_cnt[1] !== 8'd255) $display("FAIL grant_cnt_255: got %0d want 255", grant_cnt[1]);
                else passed++;
            end
        end
        total++;
        if (grant_cnt !== 32'h0) $display("FAIL grant_cnt_wrap: got %h want 00000000", grant_cnt);
        else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_skip();
        test_random();
`ifdef ARB4_GRANT_CNT_EN
        test_grant_cnt();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
